// File: rtl/irq_aggregator.sv
// rtl/irq_aggregator.sv - interrupt source aggregator feeding the PC-steering interrupt controller
// Synchronizes, latches, masks and prioritizes sources; presents one request at a time.
module irq_aggregator #(
   parameter int                     NUM_SOURCES      = 4,
   parameter int                     ID_W             = 2,
   parameter logic [10:0]            INTERRUPT_VECTOR = 11'h4,
   parameter logic [1:0]             PC_SAVE          = 2'h3,
   parameter logic [NUM_SOURCES-1:0] MASK_RESET       = '0
) (
   input  logic                   instr_clock,
   input  logic                   reset_n,
   input  logic [NUM_SOURCES-1:0] irq_src,
   input  logic [NUM_SOURCES-1:0] edge_sel,
   input  logic                   mask_we,
   input  logic [NUM_SOURCES-1:0] mask_wdata,
   input  logic [10:0]            pc_out,
   input  logic [1:0]             pc_mux_control,
   output logic                   irq,
   output logic [ID_W-1:0]        irq_id,
   output logic [NUM_SOURCES-1:0] pending,
   output logic [NUM_SOURCES-1:0] mask,
   output logic                   in_service
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQUEST = 2'd1,
      ST_SERVICE = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [NUM_SOURCES-1:0] s1_q, s2_q, s2_hist_q;
   logic [NUM_SOURCES-1:0] pending_q, pending_d;
   logic [NUM_SOURCES-1:0] mask_q, mask_d;
   logic [ID_W-1:0]        irq_id_q, irq_id_d;

   logic [NUM_SOURCES-1:0] eligible;
   logic [NUM_SOURCES-1:0] rise;
   logic [NUM_SOURCES-1:0] take_clr;
   logic [NUM_SOURCES-1:0] one_hot_base;
   logic [ID_W-1:0]        winner_id;
   logic                   winner_vld;
   logic                   take;

   assign eligible     = pending_q & mask_q;
   assign rise         = s2_q & ~s2_hist_q;
   assign one_hot_base = {{(NUM_SOURCES-1){1'b0}}, 1'b1};
   assign take         = (state_q == ST_REQUEST) && (pc_out == INTERRUPT_VECTOR);
   assign take_clr     = take ? (one_hot_base << irq_id_q) : '0;

   // Scan from the top down so the lowest eligible index is the last one written.
   always_comb begin
      winner_id  = '0;
      winner_vld = 1'b0;
      for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            winner_vld = 1'b1;
            winner_id  = ID_W'(i);
         end
      end
   end

   // Edge sources: a new rising edge beats a coincident take-clear. Level sources follow the line.
   always_comb begin
      pending_d = (edge_sel & ((pending_q & ~take_clr) | rise)) | (~edge_sel & s2_q);
      mask_d    = mask_we ? mask_wdata : mask_q;
   end

   always_comb begin
      state_d  = state_q;
      irq_id_d = irq_id_q;
      case (state_q)
         ST_IDLE: begin
            if (winner_vld) begin
               state_d  = ST_REQUEST;
               irq_id_d = winner_id;
            end
         end
         ST_REQUEST: begin
            if (take) state_d = ST_SERVICE;
         end
         ST_SERVICE: begin
            if (pc_mux_control == PC_SAVE) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge instr_clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_q      <= '0;
         s2_q      <= '0;
         s2_hist_q <= '0;
         pending_q <= '0;
         mask_q    <= MASK_RESET;
         irq_id_q  <= '0;
         state_q   <= ST_IDLE;
      end else begin
         s1_q      <= irq_src;
         s2_q      <= s1_q;
         s2_hist_q <= s2_q;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         irq_id_q  <= irq_id_d;
         state_q   <= state_d;
      end
   end

   assign irq        = (state_q == ST_REQUEST);
   assign in_service = (state_q == ST_SERVICE);
   assign irq_id     = irq_id_q;
   assign pending    = pending_q;
   assign mask       = mask_q;

endmodule

// File: tb/tb_irq_aggregator.sv
// tb/tb_irq_aggregator.sv - directed self-checking bench for irq_aggregator
module tb_irq_aggregator;

   logic        instr_clock = 1'b0;
   logic        reset_n;
   logic [3:0]  irq_src;
   logic [3:0]  edge_sel;
   logic        mask_we;
   logic [3:0]  mask_wdata;
   logic [10:0] pc_out;
   logic [1:0]  pc_mux_control;
   logic        irq;
   logic [1:0]  irq_id;
   logic [3:0]  pending;
   logic [3:0]  mask;
   logic        in_service;

   int n_cmp  = 0;
   int n_fail = 0;

   irq_aggregator dut (
      .instr_clock    (instr_clock),
      .reset_n        (reset_n),
      .irq_src        (irq_src),
      .edge_sel       (edge_sel),
      .mask_we        (mask_we),
      .mask_wdata     (mask_wdata),
      .pc_out         (pc_out),
      .pc_mux_control (pc_mux_control),
      .irq            (irq),
      .irq_id         (irq_id),
      .pending        (pending),
      .mask           (mask),
      .in_service     (in_service)
   );

   always #5 instr_clock = ~instr_clock;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge instr_clock);
         #1;
      end
   endtask

   task automatic pulse(input logic [3:0] m);
      irq_src = irq_src | m;
      tick();
      irq_src = irq_src & ~m;
   endtask

   task automatic write_mask(input logic [3:0] m);
      mask_we    = 1'b1;
      mask_wdata = m;
      tick();
      mask_we    = 1'b0;
   endtask

   task automatic enter_isr();
      pc_out = 11'h4;
      tick();
      pc_out = 11'h0;
   endtask

   task automatic do_rfi();
      pc_mux_control = 2'h3;
      tick();
      pc_mux_control = 2'h0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; irq_src = '0; edge_sel = 4'b1111; mask_we = 1'b0;
      mask_wdata = '0; pc_out = '0; pc_mux_control = '0;
      #2;
      n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
      n_cmp++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL reset_in_service: got %b want 0", in_service); end
      n_cmp++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending: got %b want 0000", pending); end
      n_cmp++; if (mask !== 4'b0000) begin n_fail++; $display("FAIL reset_mask: got %b want 0000", mask); end
      n_cmp++; if (irq_id !== 2'd0) begin n_fail++; $display("FAIL reset_irq_id: got %0d want 0", irq_id); end
      tick(2);
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_single_edge();
      write_mask(4'b1111);
      n_cmp++; if (mask !== 4'b1111) begin n_fail++; $display("FAIL t1_mask: got %b want 1111", mask); end
      pulse(4'b0100);
      tick();
      n_cmp++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL t1_pending_k1: got %b want 0000", pending); end
      tick();
      n_cmp++; if (pending !== 4'b0100) begin n_fail++; $display("FAIL t1_pending_k2: got %b want 0100", pending); end
      n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL t1_irq_k2: got %b want 0", irq); end
      tick();
      n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL t1_irq_k3: got %b want 1", irq); end
      n_cmp++; if (irq_id !== 2'd2) begin n_fail++; $display("FAIL t1_irq_id: got %0d want 2", irq_id); end
      enter_isr();
      n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL t1_irq_isr: got %b want 0", irq); end
      n_cmp++; if (in_service !== 1'b1) begin n_fail++; $display("FAIL t1_in_service: got %b want 1", in_service); end
      n_cmp++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL t1_pending_clr: got %b want 0000", pending); end
      do_rfi();
      n_cmp++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL t1_rfi: got %b want 0", in_service); end
   endtask

   task automatic test_priority();
      pulse(4'b1010);
      tick(3);
      n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL t2_irq_a: got %b want 1", irq); end
      n_cmp++; if (irq_id !== 2'd1) begin n_fail++; $display("FAIL t2_id_a: got %0d want 1", irq_id); end
      enter_isr();
      tick(2);
      n_cmp++; if (pending !== 4'b1000) begin n_fail++; $display("FAIL t2_pending_isr: got %b want 1000", pending); end
      n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL t2_no_nest: got %b want 0", irq); end
      n_cmp++; if (irq_id !== 2'd1) begin n_fail++; $display("FAIL t2_id_hold: got %0d want 1", irq_id); end
      do_rfi();
      n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL t2_gap: got %b want 0", irq); end
      tick();
      n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL t2_irq_b: got %b want 1", irq); end
      n_cmp++; if (irq_id !== 2'd3) begin n_fail++; $display("FAIL t2_id_b: got %0d want 3", irq_id); end
      enter_isr();
      do_rfi();
   endtask

   task automatic test_mask();
      write_mask(4'b0000);
      pulse(4'b0001);
      tick(3);
      n_cmp++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL t3_pending: got %b want 0001", pending); end
      n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL t3_masked_irq: got %b want 0", irq); end
      write_mask(4'b0001);
      n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL t3_old_mask: got %b want 0", irq); end
      tick();
      n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL t3_unmask_irq: got %b want 1", irq); end
      n_cmp++; if (irq_id !== 2'd0) begin n_fail++; $display("FAIL t3_id: got %0d want 0", irq_id); end
      enter_isr();
      do_rfi();
      write_mask(4'b1111);
   endtask

   task automatic test_level();
      edge_sel   = 4'b1110;
      irq_src[0] = 1'b1;
      tick(4);
      n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL t4_irq_a: got %b want 1", irq); end
      enter_isr();
      n_cmp++; if (pending[0] !== 1'b1) begin n_fail++; $display("FAIL t4_level_kept: got %b want 1", pending[0]); end
      do_rfi();
      tick();
      n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL t4_rerequest: got %b want 1", irq); end
      n_cmp++; if (irq_id !== 2'd0) begin n_fail++; $display("FAIL t4_rerequest_id: got %0d want 0", irq_id); end
      enter_isr();
      irq_src[0] = 1'b0;
      tick(3);
      n_cmp++; if (pending[0] !== 1'b0) begin n_fail++; $display("FAIL t4_level_drop: got %b want 0", pending[0]); end
      do_rfi();
      tick(2);
      n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL t4_no_rerequest: got %b want 0", irq); end
      edge_sel = 4'b1111;
   endtask

   task automatic test_back_to_back();
      pulse(4'b0010);
      tick(3);
      enter_isr();
      pulse(4'b0001);
      tick(3);
      n_cmp++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL t5_pending: got %b want 0001", pending); end
      n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL t5_held: got %b want 0", irq); end
      n_cmp++; if (in_service !== 1'b1) begin n_fail++; $display("FAIL t5_in_service: got %b want 1", in_service); end
      do_rfi();
      tick();
      n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL t5_irq: got %b want 1", irq); end
      n_cmp++; if (irq_id !== 2'd0) begin n_fail++; $display("FAIL t5_id: got %0d want 0", irq_id); end
      enter_isr();
      do_rfi();
      do_rfi();
      n_cmp++; if (irq !== 1'b0 || in_service !== 1'b0) begin n_fail++; $display("FAIL t5_spurious_rfi: got irq=%b isv=%b want 0 0", irq, in_service); end
      n_cmp++; if (irq_id !== 2'd0) begin n_fail++; $display("FAIL t5_spurious_id: got %0d want 0", irq_id); end
   endtask

   task automatic test_reset_in_service();
      pulse(4'b0100);
      tick(3);
      enter_isr();
      pulse(4'b1000);
      tick(3);
      n_cmp++; if (in_service !== 1'b1 || pending !== 4'b1000) begin n_fail++; $display("FAIL t6_pre: got isv=%b pend=%b want 1 1000", in_service, pending); end
      #2;
      reset_n = 1'b0;
      #1;
      n_cmp++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL t6_in_service: got %b want 0", in_service); end
      n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL t6_irq: got %b want 0", irq); end
      n_cmp++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL t6_pending: got %b want 0000", pending); end
      n_cmp++; if (mask !== 4'b0000) begin n_fail++; $display("FAIL t6_mask: got %b want 0000", mask); end
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_edge();
      test_priority();
      test_mask();
      test_level();
      test_back_to_back();
      test_reset_in_service();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
